// File: rtl/min_pkg.sv
// Shared state encoding and default sizes for min_accum and min_lane.
// IDX_NONE marks "no beat improved this lane" when MIN_ACCUM_ARGMIN_EN is defined.
package min_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   localparam int W_DEF     = 16;
   localparam int LANES_DEF = 4;
   localparam int KW_DEF    = 8;

   // Sliced down to KW bits where used; KW is at most 32.
   localparam logic [31:0] IDX_NONE = '1;

endpackage

// File: rtl/min_lane.sv
// One lane of the running-minimum accumulator: compare-and-hold of the current minimum.
// With MIN_ACCUM_ARGMIN_EN defined it also tracks the step index of the winning beat.
module min_lane
   import min_pkg::*;
#(
   parameter int W  = W_DEF
`ifdef MIN_ACCUM_ARGMIN_EN
   , parameter int KW = KW_DEF
`endif
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_load,
   input  logic [W-1:0]  i_init,
   input  logic          i_beat,
   input  logic [W-1:0]  i_data,
`ifdef MIN_ACCUM_ARGMIN_EN
   input  logic [KW-1:0] i_step,
   output logic [KW-1:0] o_idx,
`endif
   output logic [W-1:0]  o_acc
);

   logic [W-1:0] r_acc;
   logic         w_take;

   // Strict less-than: a tie keeps the older value (and its index).
   assign w_take = i_beat && (i_data < r_acc);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
      end else if (i_load) begin
         r_acc <= i_init;
      end else if (w_take) begin
         r_acc <= i_data;
      end
   end

   assign o_acc = r_acc;

`ifdef MIN_ACCUM_ARGMIN_EN
   logic [KW-1:0] r_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx <= IDX_NONE[KW-1:0];
      end else if (i_load) begin
         r_idx <= IDX_NONE[KW-1:0];
      end else if (w_take) begin
         r_idx <= i_step;
      end
   end

   assign o_idx = r_idx;
`endif

endmodule

// File: rtl/min_accum.sv
// Multi-lane running-minimum accumulator over k_len streamed beats.
// Optional per-lane argmin output out_idx is enabled by defining MIN_ACCUM_ARGMIN_EN.
//
// state | meaning
// IDLE  | waiting for start; start latches c_init and k_len
// ACC   | consuming beats (in_ready=1); leaves after the beat with remaining=1
// OUT   | result held on out_data with out_valid=1 until out_ready
module min_accum
   import min_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int LANES = LANES_DEF,
   parameter int KW    = KW_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [KW-1:0]       k_len,
   input  logic [LANES*W-1:0]  c_init,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [LANES*W-1:0]  in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [LANES*W-1:0]  out_data,
   output logic                busy
`ifdef MIN_ACCUM_ARGMIN_EN
   , output logic [LANES*KW-1:0] out_idx
`endif
);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [KW-1:0] r_remaining;
   logic          w_load;
   logic          w_beat;
   logic          w_last;

   assign w_load = (r_state == IDLE) && start;
   assign w_beat = (r_state == ACC) && in_valid;
   assign w_last = (r_remaining == KW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (start) w_state_nxt = (k_len == '0) ? OUT : ACC;
         ACC:  if (in_valid && w_last) w_state_nxt = OUT;
         OUT:  if (out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_remaining <= '0;
      end else if (w_load) begin
         r_remaining <= k_len;
      end else if (w_beat) begin
         r_remaining <= r_remaining - KW'(1);
      end
   end

`ifdef MIN_ACCUM_ARGMIN_EN
   // The step count is only observable through out_idx, so it lives with the argmin logic.
   logic [KW-1:0] r_step;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_step <= '0;
      end else if (w_load) begin
         r_step <= '0;
      end else if (w_beat) begin
         r_step <= r_step + KW'(1);
      end
   end
`endif

   assign in_ready  = (r_state == ACC);
   assign out_valid = (r_state == OUT);
   assign busy      = (r_state != IDLE);

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      min_lane #(
         .W  (W)
`ifdef MIN_ACCUM_ARGMIN_EN
         , .KW (KW)
`endif
      ) u_lane (
         .clk    (clk),
         .rst_n  (rst_n),
         .i_load (w_load),
         .i_init (c_init[g*W +: W]),
         .i_beat (w_beat),
         .i_data (in_data[g*W +: W]),
`ifdef MIN_ACCUM_ARGMIN_EN
         .i_step (r_step),
         .o_idx  (out_idx[g*KW +: KW]),
`endif
         .o_acc  (out_data[g*W +: W])
      );
   end

endmodule

// File: tb/tb_min_accum.sv
// Directed, table-driven bench for min_accum (default parameters).
// Index checks are compiled in when MIN_ACCUM_ARGMIN_EN is defined.
module tb_min_accum;

   localparam int W     = 16;
   localparam int LANES = 4;
   localparam int KW    = 8;
   localparam int DW    = LANES * W;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [KW-1:0] k_len = '0;
   logic [DW-1:0] c_init = '0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          out_ready = 1'b0;
   wire           in_ready;
   wire           out_valid;
   wire  [DW-1:0] out_data;
   wire           busy;
`ifdef MIN_ACCUM_ARGMIN_EN
   wire  [LANES*KW-1:0] out_idx;
`endif

   min_accum #(.W(W), .LANES(LANES), .KW(KW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .k_len     (k_len),
      .c_init    (c_init),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
`ifdef MIN_ACCUM_ARGMIN_EN
      , .out_idx (out_idx)
`endif
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic [7:0]        k;
      logic [3:0]        stall;
      logic [3:0]        hold;
      logic [63:0]       cinit;
      logic [0:3][63:0]  beats;
      logic [63:0]       exp;
      logic [31:0]       exp_idx;
   } vec_t;

   vec_t vecs[5];

   // Inputs change and outputs are sampled at the falling edge; transfers occur on the rising edge.
   task automatic run_vec(input vec_t v, input int id);
      @(negedge clk);
      chk($sformatf("v%0d_idle_before", id), {63'd0, busy}, 64'd0);
      start = 1'b1; k_len = v.k; c_init = v.cinit;
      @(negedge clk);
      start = 1'b0; k_len = '0; c_init = '0;
      for (int b = 0; b < int'(v.k); b++) begin
         for (int s = 0; s < int'(v.stall); s++) begin
            in_valid = 1'b0; in_data = '0;
            @(negedge clk);
         end
         chk($sformatf("v%0d_in_ready_b%0d", id, b), {63'd0, in_ready}, 64'd1);
         chk($sformatf("v%0d_no_early_out_b%0d", id, b), {63'd0, out_valid}, 64'd0);
         in_valid = 1'b1; in_data = v.beats[b];
         @(negedge clk);
      end
      in_valid = 1'b0; in_data = '0;
      chk($sformatf("v%0d_out_valid", id), {63'd0, out_valid}, 64'd1);
      chk($sformatf("v%0d_in_ready_off", id), {63'd0, in_ready}, 64'd0);
      chk($sformatf("v%0d_out_data", id), out_data, v.exp);
`ifdef MIN_ACCUM_ARGMIN_EN
      chk($sformatf("v%0d_out_idx", id), {32'd0, out_idx}, {32'd0, v.exp_idx});
`endif
      for (int h = 0; h < int'(v.hold); h++) begin
         out_ready = 1'b0; start = 1'b1; k_len = 8'd1; c_init = '0;
         @(negedge clk);
         chk($sformatf("v%0d_hold_valid_%0d", id, h), {63'd0, out_valid}, 64'd1);
         chk($sformatf("v%0d_hold_data_%0d", id, h), out_data, v.exp);
      end
      start = 1'b0; k_len = '0; c_init = '0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk($sformatf("v%0d_valid_drop", id), {63'd0, out_valid}, 64'd0);
      chk($sformatf("v%0d_busy_drop", id), {63'd0, busy}, 64'd0);
   endtask

   initial begin
      int   n_acc;
      int   cyc;
      logic early;
      logic [15:0] val;

      vecs[0] = '{k: 8'd3, stall: 4'd1, hold: 4'd0,
                  cinit: {16'd60, 16'hFFFF, 16'd10, 16'd100},
                  beats: '{{16'd60, 16'h8000, 16'd20, 16'd50},
                           {16'd61, 16'h8000, 16'd5,  16'd70},
                           {16'd59, 16'h7FFF, 16'd5,  16'd20},
                           64'd0},
                  exp: {16'd59, 16'h7FFF, 16'd5, 16'd20},
                  exp_idx: {8'd2, 8'd2, 8'd1, 8'd2}};
      vecs[1] = '{k: 8'd0, stall: 4'd0, hold: 4'd2,
                  cinit: {4{16'h1234}},
                  beats: '{64'd0, 64'd0, 64'd0, 64'd0},
                  exp: {4{16'h1234}},
                  exp_idx: 32'hFFFF_FFFF};
      vecs[2] = '{k: 8'd1, stall: 4'd0, hold: 4'd0,
                  cinit: {4{16'd5}},
                  beats: '{{4{16'd5}}, 64'd0, 64'd0, 64'd0},
                  exp: {4{16'd5}},
                  exp_idx: 32'hFFFF_FFFF};
      vecs[3] = '{k: 8'd4, stall: 4'd3, hold: 4'd10,
                  cinit: {4{16'hFFFF}},
                  beats: '{{16'd3, 16'hFFFF, 16'd0, 16'd9},
                           {16'd0, 16'hFFFF, 16'd1, 16'd8},
                           {16'd0, 16'hFFFF, 16'd2, 16'd7},
                           {16'd5, 16'hFFFF, 16'd3, 16'd6}},
                  exp: {16'd0, 16'hFFFF, 16'd0, 16'd6},
                  exp_idx: {8'd1, 8'hFF, 8'd0, 8'd3}};
      vecs[4] = '{k: 8'd2, stall: 4'd2, hold: 4'd1,
                  cinit: {16'd0, 16'd0, 16'd1, 16'd0},
                  beats: '{64'd0, 64'd0, 64'd0, 64'd0},
                  exp: 64'd0,
                  exp_idx: {8'hFF, 8'hFF, 8'd0, 8'hFF}};

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_flags", {61'd0, out_valid, busy, in_ready}, 64'd0);
`ifdef MIN_ACCUM_ARGMIN_EN
      chk("rst_out_idx", {32'd0, out_idx}, 64'hFFFF_FFFF);
`endif
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

      // Long run: 255 beats with random in_valid, strictly decreasing values ending at 1
      @(negedge clk);
      start = 1'b1; k_len = 8'd255; c_init = {4{16'hFFFF}};
      @(negedge clk);
      start = 1'b0; k_len = '0; c_init = '0;
      n_acc = 0; cyc = 0; early = 1'b0;
      while (n_acc < 255 && cyc < 3000 && !early) begin
         if ($urandom_range(0, 1) == 1) begin
            if (in_ready !== 1'b1) early = 1'b1;
            val = (n_acc == 0) ? 16'hFFFF : 16'(255 - n_acc);
            in_valid = 1'b1; in_data = {4{val}};
            n_acc++;
         end else begin
            in_valid = 1'b0; in_data = '0;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0; in_data = '0;
      chk("long_no_early_end", {63'd0, early}, 64'd0);
      chk("long_beats", 64'(n_acc), 64'd255);
      chk("long_out_valid", {63'd0, out_valid}, 64'd1);
      chk("long_out_data", out_data, {4{16'h0001}});
`ifdef MIN_ACCUM_ARGMIN_EN
      chk("long_out_idx", {32'd0, out_idx}, {32'd0, {4{8'd254}}});
`endif
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("long_idle", {62'd0, out_valid, busy}, 64'd0);

      // Reset mid-accumulation after 2 of 4 beats
      start = 1'b1; k_len = 8'd4; c_init = {4{16'd100}};
      @(negedge clk);
      start = 1'b0; k_len = '0; c_init = '0;
      for (int b = 0; b < 2; b++) begin
         in_valid = 1'b1; in_data = {4{16'd10}};
         @(negedge clk);
      end
      in_valid = 1'b0; in_data = '0;
      chk("mid_busy_before_rst", {63'd0, busy}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_data", out_data, 64'd0);
      chk("mid_rst_flags", {61'd0, out_valid, busy, in_ready}, 64'd0);
`ifdef MIN_ACCUM_ARGMIN_EN
      chk("mid_rst_out_idx", {32'd0, out_idx}, 64'hFFFF_FFFF);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         in_valid = 1'b1; in_data = {4{16'd5}};
         @(negedge clk);
         chk($sformatf("post_rst_quiet_%0d", c), {61'd0, out_valid, busy, in_ready}, 64'd0);
      end
      in_valid = 1'b0; in_data = '0;
      chk("post_rst_data", out_data, 64'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
